// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers.
// Segment bit order is g..a from MSB to LSB.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  typedef logic [SEG_G:SEG_A] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  function automatic seg_t seg_pol(
    input seg_t v,
    input logic low
  );
    return low ? ~v : v;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// BCD digit to active-high segment pattern.
// Codes 10..15 decode to blank.
module bcd_seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with
// shadow load, leading-zero blanking and anode guard.
module bcd_7seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_LOW  = (AN_ACTIVE_LOW != 0);
  localparam logic BLK_EN  = (BLANK_LEADING != 0);

  logic [NUM_DIGITS-1:0][3:0] sh_bcd;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic [PW-1:0]              pres;
  logic [IW-1:0]              idx;

  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] one_hot;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [3:0]            cur;
  seg_t                  dec_seg;
  seg_t                  seg_nxt;
  logic                  blank;
  logic                  last_tick;
  logic                  last_dig;

  seg_t                  seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  fd_r;

  // lz[k]: digits NUM_DIGITS-1 down to k are all zero
  always_comb begin
    logic z;
    z  = 1'b1;
    lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z     = z & (sh_bcd[k] == 4'd0);
      lz[k] = z;
    end
  end

  assign cur       = sh_bcd[idx];
  assign last_tick = (pres == PW'(SCAN_DIV - 1));
  assign last_dig  = (idx == IW'(NUM_DIGITS - 1));
  assign blank     = BLK_EN && (idx != '0) && lz[idx];
  assign one_hot   = NUM_DIGITS'(1) << idx;
  assign an_nxt    = (pres < PW'(GUARD)) ? '0 : one_hot;
  assign seg_nxt   = blank ? SEG_BLANK : dec_seg;

  bcd_seg_decoder u_dec (
    .code (cur),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bcd <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_bcd <= bcd_in;
      sh_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres <= '0;
      idx  <= '0;
    end else if (last_tick) begin
      pres <= '0;
      idx  <= last_dig ? '0 : idx + 1'b1;
    end else begin
      pres <= pres + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b0;
      an_r  <= '0;
      fd_r  <= 1'b0;
    end else begin
      seg_r <= seg_nxt;
      dp_r  <= sh_dp[idx];
      an_r  <= an_nxt;
      fd_r  <= last_tick && last_dig;
    end
  end

  assign seg        = seg_pol(seg_r, SEG_LOW);
  assign dp         = dp_r ^ SEG_LOW;
  assign an         = an_r ^ {NUM_DIGITS{AN_LOW}};
  assign digit_idx  = idx;
  assign frame_done = fd_r;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomized bench for bcd_7seg_scan_driver against
// an arithmetic model of the scan timeline.
module tb_bcd_7seg_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int n;
  int m_bcd;
  int m_dp;
  logic [6:0] tbl [16];

  always #5 clk = ~clk;

  bcd_7seg_scan_driver #(
    .NUM_DIGITS     (N),
    .SCAN_DIV       (SD),
    .GUARD          (G),
    .BLANK_LEADING  (1),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict, step, compare
  task automatic cycle(
    input logic        ld,
    input logic [15:0] b,
    input logic [3:0]  d
  );
    int p, k, v;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    int e_idx;
    load   = ld;
    bcd_in = b;
    dp_in  = d;
    p = n % SD;
    k = (n / SD) % N;
    v = m_bcd >> (4 * k);
    e_an  = (p < G) ? 4'hF : ~(4'(1) << k);
    e_seg = (k >= 1 && v == 0) ? 7'd0 : tbl[v & 15];
    e_dp  = ((m_dp >> k) & 1) != 0;
    e_fd  = (n % (SD * N)) == (SD * N - 1);
    e_idx = ((n + 1) / SD) % N;
    @(posedge clk);
    #1;
    if (ld) begin
      m_bcd = int'(b);
      m_dp  = int'(d);
    end
    n++;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("fd", 32'(frame_done), 32'(e_fd));
    check("idx", 32'(digit_idx), 32'(e_idx));
    load = 1'b0;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++)
      cycle(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic reset_model();
    n     = 0;
    m_bcd = 0;
    m_dp  = 0;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_idx"}, 32'(digit_idx), 32'h0);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Advance until an matches; bounded
  task automatic seek_an(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle(1'b0, 16'h0, 4'h0);
      if (an == want) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int fd_at;
    logic [15:0] rb;
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
            7'b1111111, 7'b1101111, 7'd0, 7'd0,
            7'd0, 7'd0, 7'd0, 7'd0};
    reset_model();
    #22;
    check_reset_pins("rst");
    @(negedge clk);
    rst_n = 1'b1;

    fd_at = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 16'($urandom), 4'($urandom));
      if (frame_done && fd_at == 0) fd_at = i;
    end
    check("first_fd", 32'(fd_at), 32'd16);

    cycle(1'b1, 16'h1234, 4'b0100);
    seek_an(4'b1011, ok);
    check("seek_d2", 32'(ok), 32'd1);
    check("d2_seg", 32'(seg), 32'b1011011);
    check("d2_dp", 32'(dp), 32'd1);
    idle(20);

    cycle(1'b1, 16'h0007, 4'b0000);
    idle(20);
    cycle(1'b1, 16'h0000, 4'b0000);
    idle(20);
    cycle(1'b1, 16'h00A5, 4'b0000);
    idle(20);

    // Mid-slot load while digit 0 is lit
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (n % (SD * N) == 1) ok = 1'b1;
      else cycle(1'b0, 16'h0, 4'h0);
    end
    check("seek_mid", 32'(ok), 32'd1);
    cycle(1'b1, 16'h0009, 4'b0000);
    cycle(1'b0, 16'h0, 4'h0);
    check("mid_seg", 32'(seg), 32'b1101111);
    check("mid_an", 32'(an), 32'b1110);

    for (int i = 0; i < 400; i++) begin
      rb = 16'($urandom);
      rb = rb >> (4 * $urandom_range(0, 4));
      cycle(($urandom_range(0, 5) == 0), rb, 4'($urandom));
    end

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_pins("arst");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    seek_an(4'b1110, ok);
    check("seek_d0", 32'(ok), 32'd1);
    check("d0_zero", 32'(seg), 32'b0111111);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan_driver.md
Name: bcd_7seg_scan_driver

Overview:
- Multi-digit, time-multiplexed 7-segment display driver.
- Captures a packed vector of NUM_DIGITS BCD digits into a shadow register on a load strobe, then scans the digits one at a time onto a shared segment bus with per-digit anode enables.
- Adds the following per-digit features:
  - decimal points
  - optional leading-zero blanking
  - an anti-ghosting guard interval
  - configurable output polarity
- Sits between the counter/datapath logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits/anodes (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+2).
- GUARD, 2, cycles at the start of each slot with all anodes off.
- BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 is never blanked).
- SEG_ACTIVE_LOW, 0, 1 = seg/dp driven low-true.
- AN_ACTIVE_LOW, 1, 1 = an driven low-true.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- bcd_in  in  4*NUM_DIGITS  packed digits; digit 0 (least significant) = bits [3:0].
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- load  in  1  single-cycle strobe; captures bcd_in/dp_in into the shadow registers.
- seg  out  7  segment bus, bit0=a ... bit6=g.
- dp  out  1  decimal point for the currently lit digit.
- an  out  NUM_DIGITS  anode enables, one-hot when lit.
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit currently in its slot.
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Single clock domain; rst_n asynchronous assert, synchronous deassert (handled upstream).
- Reset values:
  - shadow digits = 0, shadow dp = 0
  - prescaler = 0, digit_idx = 0
  - an = all inactive, seg = all inactive, dp = inactive
  - frame_done = 0
- Reset mid-scan aborts the slot immediately with no glitch to active; scan restarts at digit 0 after release.
- Load:
  - load=1 at edge t updates the shadow at t.
  - Change is visible on seg at edge t+1 if that digit is lit.
  - Shadow is held otherwise.
  - bcd_in is not sampled without load.
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- frame_done=1 for exactly the cycle in which the prescaler wraps while digit_idx = NUM_DIGITS-1.
- Guard interval: while prescaler < GUARD, an is all inactive. Otherwise an has only bit digit_idx active.
- Outputs are registered: seg/dp/an reflect the state one cycle after prescaler/digit_idx. This latency is uniform and fixed at 1.
- Decode table (active-high form):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - codes 10..15 = 0000000 (blank)
- Leading-zero blanking (BLANK_LEADING=1): digit k is blanked (seg all inactive, its anode still follows the scan) if every digit from NUM_DIGITS-1 down to k is 0, for k >= 1. Digit 0 always displays.
- dp output is independent of blanking.
- Polarity: final seg/dp inverted if SEG_ACTIVE_LOW; an inverted if AN_ACTIVE_LOW. Applied after all logic, including reset values.
- load coinciding with a slot boundary: the new shadow is used for the new slot, one cycle later, per the fixed latency.

Decomposition:
- Shared package seg7_pkg:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK
  - segment bit-order localparams
  - polarity helper function
- Sub-module bcd_seg_decoder: combinational 4-bit BCD -> 7-bit active-high pattern with blank for invalid codes. Instantiated once on the muxed digit.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, BLANK_LEADING=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1):
- Reset held then released -> an=1111, seg=0000000, dp=0, digit_idx=0. First lit cycle shows an=1110 after the guard cycle; frame_done first pulses 16 cycles after release.
- Load bcd_in=16'h1234, dp_in=4'b0100 -> successive slots show:
  - an=1110 seg=1100110 (4)
  - an=1101 seg=1001111 (3)
  - an=1011 seg=1011011 (2) dp=1
  - an=0111 seg=0000110 (1)
- Load bcd_in=16'h0007 -> digits 3,2,1 show seg=0000000 with their anodes still scanning; digit 0 shows 0000111. Then load 16'h0000 -> digit 0 shows 0111111.
- Load bcd_in=16'h00A5 -> digit 1 (code 10) blank, digit 0 = 1101101. Digits 3,2 are also blank by leading-zero rule.
- Assert load mid-slot on digit 0 with 16'h0009 -> seg changes to 1101111 exactly one cycle after the load edge. No anode change.
- Assert rst_n=0 asynchronously mid-slot -> an=1111 and seg=0000000 without waiting for clk. Shadow cleared, so after release digit 0 shows 0111111.
